// File: rtl/adc_disp_pkg.sv
// Shared types and constants for the millivolt display block:
// converter state encoding, bus widths, 7-segment codes and small helpers.
package adc_disp_pkg;

   localparam int MV_W       = 12;
   localparam int BCD_W      = 16;
   localparam int NUM_DIGITS = 4;
   localparam int SHIFT_W    = MV_W + BCD_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } conv_state_t;

   // Active-low segment codes, bit 0 = a ... bit 6 = g.
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Decimal digit to segment pattern; non-decimal codes show blank.
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] code;
      case (nib)
         4'd0:    code = SEG_0;
         4'd1:    code = SEG_1;
         4'd2:    code = SEG_2;
         4'd3:    code = SEG_3;
         4'd4:    code = SEG_4;
         4'd5:    code = SEG_5;
         4'd6:    code = SEG_6;
         4'd7:    code = SEG_7;
         4'd8:    code = SEG_8;
         4'd9:    code = SEG_9;
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

   // Double-dabble nibble correction; 4-bit wrap, no carry out.
   function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
      logic [3:0] res;
      if (nib >= 4'd5) begin
         res = nib + 4'd3;
      end else begin
         res = nib;
      end
      return res;
   endfunction

endpackage

// File: rtl/mv_bin2bcd.sv
// Sequential 12-bit binary to 4-digit BCD converter (shift-add-3).
// start is taken in IDLE; bin is sampled in LOAD; bcd and a one-cycle
// done pulse are registered on leaving DONE.
module mv_bin2bcd
   import adc_disp_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [MV_W-1:0]   bin,
   output logic              busy,
   output logic              done,
   output logic [BCD_W-1:0]  bcd
);

   conv_state_t          state_r, state_nxt;
   logic [SHIFT_W-1:0]   shift_r, shift_nxt;
   logic [SHIFT_W-1:0]   adj_s;
   logic [3:0]           iter_r, iter_nxt;
   logic [BCD_W-1:0]     bcd_r, bcd_nxt;
   logic                 done_r, done_nxt;

   // State register of the conversion engine.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Next-state and datapath: load, 12 adjust+shift steps, publish.
   always_comb begin
      state_nxt = state_r;
      shift_nxt = shift_r;
      iter_nxt  = iter_r;
      bcd_nxt   = bcd_r;
      done_nxt  = 1'b0;
      adj_s     = shift_r;
      adj_s[MV_W+3  -: 4] = bcd_adjust(shift_r[MV_W+3  -: 4]);
      adj_s[MV_W+7  -: 4] = bcd_adjust(shift_r[MV_W+7  -: 4]);
      adj_s[MV_W+11 -: 4] = bcd_adjust(shift_r[MV_W+11 -: 4]);
      adj_s[MV_W+15 -: 4] = bcd_adjust(shift_r[MV_W+15 -: 4]);
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt = LOAD;
            end else begin
               state_nxt = IDLE;
            end
         end
         LOAD: begin
            shift_nxt = {{BCD_W{1'b0}}, bin};
            iter_nxt  = 4'd0;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            shift_nxt = {adj_s[SHIFT_W-2:0], 1'b0};
            iter_nxt  = iter_r + 4'd1;
            if (iter_r == 4'd11) begin
               state_nxt = DONE;
            end else begin
               state_nxt = SHIFT;
            end
         end
         DONE: begin
            bcd_nxt   = shift_r[SHIFT_W-1:MV_W];
            done_nxt  = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_r <= '0;
         iter_r  <= 4'd0;
         bcd_r   <= '0;
         done_r  <= 1'b0;
      end else begin
         shift_r <= shift_nxt;
         iter_r  <= iter_nxt;
         bcd_r   <= bcd_nxt;
         done_r  <= done_nxt;
      end
   end

   assign busy = (state_r != IDLE);
   assign done = done_r;
   assign bcd  = bcd_r;

endmodule

// File: rtl/adc_mv_display.sv
// Millivolt display: synchronises and filters the asynchronous mv_in bus,
// converts accepted values to BCD and scans a 4-digit common-anode display.
// Build option: define ADC_DISP_LZB_EN for leading-zero blanking of the
// thousands, hundreds and tens digits (bcd output is unaffected).
module adc_mv_display
   import adc_disp_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [MV_W-1:0]   mv_in,
   output logic [6:0]        seg,
   output logic [3:0]        an,
   output logic [BCD_W-1:0]  bcd,
   output logic              bcd_valid
);

   localparam int              CNT_W   = 20;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   logic [MV_W-1:0]   s1_r, s2_r, last_r;
   logic              accept_s;
   logic              conv_busy_s;
   logic              conv_done_s;
   logic [BCD_W-1:0]  conv_bcd_s;
   logic [CNT_W-1:0]  refresh_cnt_r;
   logic [1:0]        digit_idx_r;
   logic [3:0]        nib_s;
   logic              blank_s;
   logic [6:0]        seg_nxt, seg_r;
   logic [3:0]        an_nxt, an_r;

   // A value is taken only when two consecutive samples agree and it is new.
   assign accept_s = (s1_r == s2_r) && (s2_r != last_r) && !conv_busy_s;

   // Two-stage capture of mv_in and the last accepted value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_r   <= '0;
         s2_r   <= '0;
         last_r <= '0;
      end else begin
         s1_r <= mv_in;
         s2_r <= s1_r;
         if (accept_s) begin
            last_r <= s2_r;
         end else begin
            last_r <= last_r;
         end
      end
   end

   mv_bin2bcd u_bin2bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (accept_s),
      .bin   (last_r),
      .busy  (conv_busy_s),
      .done  (conv_done_s),
      .bcd   (conv_bcd_s)
   );

   // Digit dwell counter and digit index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         refresh_cnt_r <= '0;
         digit_idx_r   <= 2'd0;
      end else if (refresh_cnt_r == CNT_MAX) begin
         refresh_cnt_r <= '0;
         digit_idx_r   <= digit_idx_r + 2'd1;
      end else begin
         refresh_cnt_r <= refresh_cnt_r + CNT_W'(1);
         digit_idx_r   <= digit_idx_r;
      end
   end

   // Select the current digit of the published bcd and form seg/an.
   always_comb begin
      nib_s   = 4'd0;
      blank_s = 1'b0;
      case (digit_idx_r)
         2'd0:    nib_s = conv_bcd_s[3:0];
         2'd1:    nib_s = conv_bcd_s[7:4];
         2'd2:    nib_s = conv_bcd_s[11:8];
         2'd3:    nib_s = conv_bcd_s[15:12];
         default: nib_s = 4'd0;
      endcase
`ifdef ADC_DISP_LZB_EN
      case (digit_idx_r)
         2'd1:    blank_s = (conv_bcd_s[15:4]  == 12'd0);
         2'd2:    blank_s = (conv_bcd_s[15:8]  == 8'd0);
         2'd3:    blank_s = (conv_bcd_s[15:12] == 4'd0);
         default: blank_s = 1'b0;
      endcase
`else
      blank_s = 1'b0;
`endif
      if (blank_s) begin
         seg_nxt = SEG_BLANK;
      end else begin
         seg_nxt = seg_decode(nib_s);
      end
      an_nxt = ~(4'b0001 << digit_idx_r);
   end

   // seg and an share one register stage so they switch together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_r <= SEG_BLANK;
         an_r  <= 4'hF;
      end else begin
         seg_r <= seg_nxt;
         an_r  <= an_nxt;
      end
   end

   assign seg       = seg_r;
   assign an        = an_r;
   assign bcd       = conv_bcd_s;
   assign bcd_valid = conv_done_s;

endmodule
